// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-style control FSM.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath enables and selects.
// Optional feature: define JUMP_EN to decode jal (1101111) and jalr (1100111).
// Without JUMP_EN those opcodes are illegal, and the JAL/JALR states cannot be reached.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       branch_cond_i,
  output logic       IR_Write_o,
  output logic       PC_Write_o,
  output logic       Mem_Write_o,
  output logic       Mem_Read_o,
  output logic       Reg_Write_o,
  output logic       IorD_o,
  output logic       PC_Src_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [1:0] Mem_to_Reg_o,
  output logic [2:0] ALU_Op_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  // Opcode field encodings recognised in DECODE
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ALU control codes
  localparam logic [2:0] ALU_R    = 3'b000;
  localparam logic [2:0] ALU_IAR  = 3'b001;
  localparam logic [2:0] ALU_MEM  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_BR   = 3'b101;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EX_R    = 4'd2,
    EX_I    = 4'd3,
    EX_ADDR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_MEM  = 4'd7,
    WB_ALU  = 4'd8,
    EX_BR   = 4'd9,
    EX_LUI  = 4'd10,
    JAL     = 4'd11,
    JALR    = 4'd12
  } state_t;

  // Registered control word. fetch/decode/branch are qualifiers that are
  // combined with live inputs; everything else goes straight to the ports.
  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       branch;
    logic       pc_write;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       iord;
    logic       pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  // Moore control word for a given state; anything not listed stays zero.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch    = 1'b1;
        c.mem_read = 1'b1;
        c.src_a    = 2'b00;
        c.src_b    = 2'b01;
        c.alu_op   = ALU_ADD;
      end
      DECODE: begin
        c.decode = 1'b1;
        c.src_a  = 2'b10;
        c.src_b  = 2'b10;
        c.alu_op = ALU_ADD;
      end
      EX_R: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b00;
        c.alu_op = ALU_R;
      end
      EX_I: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b10;
        c.alu_op = ALU_IAR;
      end
      EX_LUI: begin
        c.src_b  = 2'b10;
        c.alu_op = ALU_LUI;
      end
      EX_ADDR: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b10;
        c.alu_op = ALU_MEM;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
      end
      WB_ALU: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b00;
      end
      EX_BR: begin
        c.branch = 1'b1;
        c.src_a  = 2'b01;
        c.src_b  = 2'b00;
        c.alu_op = ALU_BR;
        c.pc_src = 1'b1;
      end
`ifdef JUMP_EN
      JAL: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
        c.pc_src     = 1'b1;
        c.pc_write   = 1'b1;
      end
      JALR: begin
        c.src_a      = 2'b01;
        c.src_b      = 2'b10;
        c.alu_op     = ALU_ADD;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
        c.pc_src     = 1'b0;
        c.pc_write   = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // True when DECODE knows where to send this opcode.
  function automatic logic opcode_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_LUI: ok = 1'b1;
`ifdef JUMP_EN
      OP_JAL, OP_JALR: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state selection. FETCH only advances once its control word is live,
  // so the idle cycle straight after reset re-enters FETCH properly.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = (ctrl_q.fetch && mem_ready_i) ? DECODE : FETCH;
      DECODE: begin
        case (opcode_i)
          OP_R:     state_d = EX_R;
          OP_I:     state_d = EX_I;
          OP_LOAD:  state_d = EX_ADDR;
          OP_STORE: state_d = EX_ADDR;
          OP_BR:    state_d = EX_BR;
          OP_LUI:   state_d = EX_LUI;
`ifdef JUMP_EN
          OP_JAL:   state_d = JAL;
          OP_JALR:  state_d = JALR;
`endif
          default:  state_d = FETCH;
        endcase
      end
      EX_R:    state_d = WB_ALU;
      EX_I:    state_d = WB_ALU;
      EX_LUI:  state_d = WB_ALU;
      EX_ADDR: begin
        if (opcode_i == OP_LOAD)
          state_d = MEM_RD;
        else if (opcode_i == OP_STORE)
          state_d = MEM_WR;
        else
          state_d = FETCH;
      end
      MEM_RD:  state_d = mem_ready_i ? WB_MEM : MEM_RD;
      MEM_WR:  state_d = mem_ready_i ? FETCH : MEM_WR;
      default: state_d = FETCH;
    endcase
  end

  // State register and registered control word; reset clears both at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign IR_Write_o   = ctrl_q.fetch & mem_ready_i;
  assign PC_Write_o   = (ctrl_q.fetch & mem_ready_i) | (ctrl_q.branch & branch_cond_i) | ctrl_q.pc_write;
  assign Mem_Write_o  = ctrl_q.mem_write;
  assign Mem_Read_o   = ctrl_q.mem_read;
  assign Reg_Write_o  = ctrl_q.reg_write;
  assign IorD_o       = ctrl_q.iord;
  assign PC_Src_o     = ctrl_q.pc_src;
  assign ALU_Src_A_o  = ctrl_q.src_a;
  assign ALU_Src_B_o  = ctrl_q.src_b;
  assign Mem_to_Reg_o = ctrl_q.mem_to_reg;
  assign ALU_Op_o     = ctrl_q.alu_op;
  assign illegal_o    = ctrl_q.decode & ~opcode_legal(opcode_i);
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (honours JUMP_EN when defined).
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode_i = 7'b0110011;
  logic       mem_ready_i = 1'b0;
  logic       branch_cond_i = 1'b0;
  logic       IR_Write_o, PC_Write_o, Mem_Write_o, Mem_Read_o, Reg_Write_o, IorD_o, PC_Src_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o, Mem_to_Reg_o;
  logic [2:0] ALU_Op_o;
  logic       illegal_o;
  logic [3:0] state_o;

  int checks = 0;
  int passed = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .branch_cond_i(branch_cond_i), .IR_Write_o(IR_Write_o), .PC_Write_o(PC_Write_o),
    .Mem_Write_o(Mem_Write_o), .Mem_Read_o(Mem_Read_o), .Reg_Write_o(Reg_Write_o),
    .IorD_o(IorD_o), .PC_Src_o(PC_Src_o), .ALU_Src_A_o(ALU_Src_A_o),
    .ALU_Src_B_o(ALU_Src_B_o), .Mem_to_Reg_o(Mem_to_Reg_o), .ALU_Op_o(ALU_Op_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, then take the first edge into a live FETCH
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    mem_ready_i = 1'b0;
    branch_cond_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    mem_ready_i = 1'b1;
    opcode_i = 7'b0110011;
    #2;
    checks++; if (state_o !== 4'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state_o); else passed++;
    checks++; if ({IR_Write_o, PC_Write_o, Mem_Write_o, Reg_Write_o, illegal_o, Mem_Read_o} !== 6'b0)
      $display("[TB] FAIL reset_enables: got %b expected 000000", {IR_Write_o, PC_Write_o, Mem_Write_o, Reg_Write_o, illegal_o, Mem_Read_o}); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({state_o, Mem_Read_o, IR_Write_o} !== 6'b0) $display("[TB] FAIL reset_held: got %b expected 000000", {state_o, Mem_Read_o, IR_Write_o}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if ({state_o, Mem_Read_o, IR_Write_o, PC_Write_o} !== 7'b0000111)
      $display("[TB] FAIL reset_first_fetch: got %b expected 0000111", {state_o, Mem_Read_o, IR_Write_o, PC_Write_o}); else passed++;
    tick();
    checks++; if (state_o !== 4'd1) $display("[TB] FAIL reset_to_decode: got %0d expected 1", state_o); else passed++;
  endtask

  task automatic test_add;
    int exp_st[5] = '{0, 1, 2, 8, 0};
    do_reset();
    opcode_i = 7'b0110011;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state_o !== 4'(exp_st[i])) $display("[TB] FAIL add_state c%0d: got %0d expected %0d", i, state_o, exp_st[i]); else passed++;
      checks++; if (Reg_Write_o !== (exp_st[i] == 8)) $display("[TB] FAIL add_regwrite c%0d: got %b expected %b", i, Reg_Write_o, exp_st[i] == 8); else passed++;
      if (i == 0) begin
        checks++; if ({IR_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, IorD_o} !== 9'b1_00_01_011_0)
          $display("[TB] FAIL add_fetch_ctrl: got %b expected 100010110", {IR_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, IorD_o}); else passed++;
      end
      if (i == 1) begin
        checks++; if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, IR_Write_o} !== 8'b10_10_011_0)
          $display("[TB] FAIL add_decode_ctrl: got %b expected 10100110", {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, IR_Write_o}); else passed++;
      end
      if (i == 2) begin
        checks++; if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 7'b01_00_000)
          $display("[TB] FAIL add_exr_ctrl: got %b expected 0100000", {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o}); else passed++;
      end
      if (i == 3) begin
        checks++; if ({Mem_to_Reg_o, Mem_Write_o, Mem_Read_o} !== 4'b0000)
          $display("[TB] FAIL add_wb_ctrl: got %b expected 0000", {Mem_to_Reg_o, Mem_Write_o, Mem_Read_o}); else passed++;
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_iarith_lui;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      opcode_i = (j == 0) ? 7'b0010011 : 7'b0110111;
      mem_ready_i = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (state_o !== ((j == 0) ? 4'd3 : 4'd10)) $display("[TB] FAIL ilui_ex_state j%0d: got %0d", j, state_o); else passed++;
      checks++; if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== ((j == 0) ? 7'b01_10_001 : 7'b00_10_100))
        $display("[TB] FAIL ilui_ex_ctrl j%0d: got %b expected %b", j, {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o}, (j == 0) ? 7'b01_10_001 : 7'b00_10_100); else passed++;
      tick();
      checks++; if ({state_o, Reg_Write_o} !== 5'b1000_1) $display("[TB] FAIL ilui_wb j%0d: got %b expected 10001", j, {state_o, Reg_Write_o}); else passed++;
      tick();
      checks++; if (state_o !== 4'd0) $display("[TB] FAIL ilui_done j%0d: got %0d expected 0", j, state_o); else passed++;
    end
  endtask

  task automatic test_load_stall;
    do_reset();
    opcode_i = 7'b0000011;
    mem_ready_i = 1'b1;
    tick();
    tick();
    checks++; if ({state_o, ALU_Op_o} !== 7'b0100_010) $display("[TB] FAIL lw_exaddr: got %b expected 0100010", {state_o, ALU_Op_o}); else passed++;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = (i == 3);
      #1;
      checks++; if ({state_o, Mem_Read_o, IorD_o, Reg_Write_o} !== 7'b0101_110)
        $display("[TB] FAIL lw_memrd c%0d: got %b expected 0101110", i, {state_o, Mem_Read_o, IorD_o, Reg_Write_o}); else passed++;
      tick();
    end
    checks++; if ({state_o, Mem_to_Reg_o, Reg_Write_o, Mem_Read_o} !== 8'b0111_01_1_0)
      $display("[TB] FAIL lw_wbmem: got %b expected 01110110", {state_o, Mem_to_Reg_o, Reg_Write_o, Mem_Read_o}); else passed++;
    tick();
    checks++; if (state_o !== 4'd0) $display("[TB] FAIL lw_done: got %0d expected 0", state_o); else passed++;
  endtask

  task automatic test_store_stall;
    do_reset();
    opcode_i = 7'b0100011;
    mem_ready_i = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready_i = (i == 2);
      #1;
      checks++; if ({state_o, Mem_Write_o, IorD_o, Mem_Read_o, Reg_Write_o} !== 8'b0110_1100)
        $display("[TB] FAIL sw_memwr c%0d: got %b expected 01101100", i, {state_o, Mem_Write_o, IorD_o, Mem_Read_o, Reg_Write_o}); else passed++;
      tick();
    end
    checks++; if ({state_o, Mem_Write_o} !== 5'b0000_0) $display("[TB] FAIL sw_done: got %b expected 00000", {state_o, Mem_Write_o}); else passed++;
  endtask

  task automatic test_branch;
    for (int c = 1; c >= 0; c--) begin
      do_reset();
      opcode_i = 7'b1100011;
      mem_ready_i = 1'b1;
      branch_cond_i = (c == 1);
      tick();
      checks++; if ({state_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 11'b0001_10_10_011)
        $display("[TB] FAIL br_decode c%0d: got %b expected 00011010011", c, {state_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o}); else passed++;
      tick();
      checks++; if ({state_o, PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 12'b1001_1_01_00_101)
        $display("[TB] FAIL br_ex_ctrl c%0d: got %b expected 100110100101", c, {state_o, PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o}); else passed++;
      checks++; if (PC_Write_o !== (c == 1)) $display("[TB] FAIL br_pcwrite c%0d: got %b expected %b", c, PC_Write_o, c == 1); else passed++;
      tick();
      checks++; if (state_o !== 4'd0) $display("[TB] FAIL br_done c%0d: got %0d expected 0", c, state_o); else passed++;
    end
    branch_cond_i = 1'b0;
  endtask

  task automatic test_illegal;
    do_reset();
    opcode_i = 7'b1111111;
    mem_ready_i = 1'b1;
    tick();
    checks++; if ({state_o, illegal_o} !== 5'b0001_1) $display("[TB] FAIL ill_pulse: got %b expected 00011", {state_o, illegal_o}); else passed++;
    checks++; if ({IR_Write_o, PC_Write_o, Mem_Write_o, Reg_Write_o} !== 4'b0)
      $display("[TB] FAIL ill_writes: got %b expected 0000", {IR_Write_o, PC_Write_o, Mem_Write_o, Reg_Write_o}); else passed++;
    tick();
    checks++; if ({state_o, illegal_o, Mem_Read_o} !== 6'b0000_0_1) $display("[TB] FAIL ill_next: got %b expected 000001", {state_o, illegal_o, Mem_Read_o}); else passed++;
  endtask

  task automatic test_jump;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      opcode_i = (j == 0) ? 7'b1101111 : 7'b1100111;
      mem_ready_i = 1'b1;
      tick();
`ifdef JUMP_EN
      checks++; if ({state_o, illegal_o} !== 5'b0001_0) $display("[TB] FAIL jmp_decode j%0d: got %b expected 00010", j, {state_o, illegal_o}); else passed++;
      tick();
      checks++; if (state_o !== ((j == 0) ? 4'd11 : 4'd12)) $display("[TB] FAIL jmp_state j%0d: got %0d", j, state_o); else passed++;
      checks++; if ({PC_Write_o, Reg_Write_o, Mem_to_Reg_o, PC_Src_o} !== ((j == 0) ? 5'b1_1_10_1 : 5'b1_1_10_0))
        $display("[TB] FAIL jmp_ctrl j%0d: got %b", j, {PC_Write_o, Reg_Write_o, Mem_to_Reg_o, PC_Src_o}); else passed++;
      if (j == 1) begin
        checks++; if ({ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o} !== 7'b01_10_011)
          $display("[TB] FAIL jalr_alu: got %b expected 0110011", {ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o}); else passed++;
      end
`else
      checks++; if ({state_o, illegal_o, Reg_Write_o, PC_Write_o} !== 7'b0001_1_00)
        $display("[TB] FAIL jmp_illegal j%0d: got %b expected 0001100", j, {state_o, illegal_o, Reg_Write_o, PC_Write_o}); else passed++;
`endif
      tick();
      checks++; if (state_o !== 4'd0) $display("[TB] FAIL jmp_done j%0d: got %0d expected 0", j, state_o); else passed++;
    end
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    opcode_i = 7'b0100011;
    mem_ready_i = 1'b1;
    tick();
    tick();
    mem_ready_i = 1'b0;
    tick();
    tick();
    checks++; if ({state_o, Mem_Write_o} !== 5'b0110_1) $display("[TB] FAIL rstwr_pre: got %b expected 01101", {state_o, Mem_Write_o}); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({state_o, Mem_Write_o, IorD_o, Mem_Read_o} !== 7'b0) $display("[TB] FAIL rstwr_async: got %b expected 0000000", {state_o, Mem_Write_o, IorD_o, Mem_Read_o}); else passed++;
    mem_ready_i = 1'b1;
    #1;
    checks++; if ({IR_Write_o, PC_Write_o} !== 2'b00) $display("[TB] FAIL rstwr_gated: got %b expected 00", {IR_Write_o, PC_Write_o}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if ({state_o, Mem_Read_o, IR_Write_o} !== 6'b0000_11) $display("[TB] FAIL rstwr_resume: got %b expected 000011", {state_o, Mem_Read_o, IR_Write_o}); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops[6] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110111};
    int exp_n[6] = '{4, 5, 4, 3, 4, 4};
    do_reset();
    mem_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int n;
      opcode_i = ops[k];
      n = 0;
      do begin
        tick();
        n++;
      end while (state_o !== 4'd0 && n < 20);
      checks++; if (n !== exp_n[k]) $display("[TB] FAIL b2b_cycles op%0d: got %0d expected %0d", k, n, exp_n[k]); else passed++;
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_add();
    test_iarith_lui();
    test_load_stall();
    test_store_stall();
    test_branch();
    test_illegal();
    test_jump();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
